beat_sequencer: RTL and testbench
=================================

Name: beat_sequencer

Overview:
- Timing generator that sequences the hardwired controller: produces the one-hot phase strobes T1/T2/T3 and the beat strobes W1/W2/W3.
- Consumes the controller's short, long and stop outputs to shorten, lengthen or halt the instruction cycle.
- Resumes on the front-panel start key (qd).
- Counts completed instruction cycles for the panel display.

Parameters:
CNT_W, 16, width of the completed-instruction-cycle counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  reset, asynchronous, active-low.
- qd  input  1  start key, already debounced and synchronous to clk; only its rising edge is used.
- short  input  1  from controller: end the instruction cycle after W1.
- long  input  1  from controller: extend the instruction cycle to W3.
- stop  input  1  from controller: halt after the current beat.
- t1, t2, t3  output  1 each  one-hot phase strobes, registered.
- w1, w2, w3  output  1 each  one-hot beat strobes, registered.
- running  output  1  high while the sequencer is in RUN.
- instr_cnt  output  CNT_W  number of completed instruction cycles, registered.

Behaviour:
- Reset (clr=0, asynchronous):
  - state=HALT, phase=none, beat=none, resume_beat=W1.
  - Outputs: t1..t3=0, w1..w3=0, running=0, instr_cnt=0.
- States:
  - HALT: all t/w strobes low, running=0.
  - RUN: exactly one t and exactly one w high every cycle.
- Start edge detect:
  - qd_q is a register of qd, reset to 0.
  - start = qd & ~qd_q.
- HALT -> RUN on start. At that same edge: beat=resume_beat, phase=T1, running=1.
  - The first T1 is visible in the cycle after the edge where qd is first sampled high.
- Phase sequencing in RUN:
  - T1 -> T2 -> T3, one clk each.
  - After T3, the next beat is selected and the phase returns to T1 in the next clock (no dead cycle).
- short/long/stop are sampled only while T3 is high. Values during T1/T2 are ignored.
- Next-beat rule at T3:
  - W1: short=1 -> W1 (cycle end); otherwise -> W2.
  - W2: long=1 -> W3; otherwise -> W1 (cycle end).
  - W3: always -> W1 (cycle end).
  - short and long both high in W1: short wins. long sampled in W1 is ignored; short sampled in W2 is ignored.
- Cycle end:
  - instr_cnt increments by 1 at the T3 edge that ends the instruction cycle.
  - Wraps from 2^CNT_W-1 to 0.
  - The increment happens even if stop is also high.
- stop=1 at T3:
  - Compute the next beat as above and store it in resume_beat.
  - Go to HALT at that edge: strobes 0, running=0 in the following cycle.
  - The next start resumes at the stored beat, e.g. stop in W1 without short resumes at W2 T1.
- start while in RUN is ignored.
- qd held high produces a single start; it must go low and then high again to start again.
- clr mid-operation: immediate return to reset values regardless of phase.
  - After release, the first start begins at W1.
- Invariant: the t and w strobes are never multi-hot, and there are no glitches (all are flop outputs).

Optional Feature:
- Macro: BEAT_SINGLE_STEP_EN.
- When defined:
  - Adds input port step_mode (1 bit).
  - With step_mode=1, every cycle-end T3 behaves as if stop=1: HALT, resume_beat=W1, instr_cnt still increments.
  - Each qd press then executes exactly one instruction cycle.
  - With step_mode=0, behaviour is identical to the base block.
- When undefined: no step_mode port, and no step logic is generated.

Test Plan:
1. Reset, pulse qd, short=1 held -> W1 with T1,T2,T3 repeating every 3 clk; instr_cnt 0->1->2 at each W1 T3.
2. short=0, long=1 -> W1,W2,W3 each 3 clk; W1 again at clk 10; instr_cnt=1 after the W3 T3 edge.
3. short=0, long=0, stop=1 only during W1 T3 -> HALT with all strobes 0 and running=0; stop ignored in T1/T2. qd pulse -> W2 T1, then W1; instr_cnt=1.
4. In W1, short=1, long=1, stop=1 at T3 -> HALT, instr_cnt +1, next qd resumes at W1 T1. Holding qd high 10 clk -> only one start.
5. clr pulsed low during W2 T2 -> outputs 0 immediately and instr_cnt=0. After release, qd -> W1 T1.
6. CNT_W=4, short=1, 16 cycles -> instr_cnt 15->0. With BEAT_SINGLE_STEP_EN and step_mode=1, long=1 -> each qd runs W1,W2,W3 then HALT.

Source files
------------

// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - T1..T3 phase / W1..W3 beat timing generator for the hardwired controller.
// Optional macro BEAT_SINGLE_STEP_EN adds step_mode: halt at every instruction-cycle end.
module beat_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             qd,
   input  logic             short,
   input  logic             long,
   input  logic             stop,
`ifdef BEAT_SINGLE_STEP_EN
   input  logic             step_mode,
`endif
   output logic             t1,
   output logic             t2,
   output logic             t3,
   output logic             w1,
   output logic             w2,
   output logic             w3,
   output logic             running,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic {HALT, RUN} state_t;

   localparam logic [2:0] PH_T1 = 3'b001;
   localparam logic [2:0] PH_T2 = 3'b010;
   localparam logic [2:0] PH_T3 = 3'b100;
   localparam logic [2:0] BT_W1 = 3'b001;
   localparam logic [2:0] BT_W2 = 3'b010;
   localparam logic [2:0] BT_W3 = 3'b100;

   state_t           state_q, state_d;
   logic [2:0]       phase_q, phase_d;
   logic [2:0]       beat_q, beat_d;
   logic [2:0]       resume_q, resume_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             qd_q;

   logic             start;
   logic             cyc_end;
   logic             step_halt;
   logic [2:0]       next_beat;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q  <= HALT;
         phase_q  <= 3'b000;
         beat_q   <= 3'b000;
         resume_q <= BT_W1;
         cnt_q    <= '0;
         qd_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         beat_q   <= beat_d;
         resume_q <= resume_d;
         cnt_q    <= cnt_d;
         qd_q     <= qd;
      end
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      beat_d    = beat_q;
      resume_d  = resume_q;
      cnt_d     = cnt_q;
      start     = qd & ~qd_q;
      next_beat = BT_W1;
      cyc_end   = 1'b0;

      // short wins over long in W1; each flag is only meaningful in its own beat
      case (beat_q)
         BT_W1: begin
            if (short) cyc_end = 1'b1;
            else       next_beat = BT_W2;
         end
         BT_W2: begin
            if (long) next_beat = BT_W3;
            else      cyc_end = 1'b1;
         end
         default: cyc_end = 1'b1;
      endcase

`ifdef BEAT_SINGLE_STEP_EN
      step_halt = step_mode & cyc_end;
`else
      step_halt = 1'b0;
`endif

      case (state_q)
         HALT: begin
            if (start) begin
               state_d = RUN;
               phase_d = PH_T1;
               beat_d  = resume_q;
            end
         end
         default: begin
            case (phase_q)
               PH_T1:   phase_d = PH_T2;
               PH_T2:   phase_d = PH_T3;
               default: begin
                  if (cyc_end) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                  if (stop || step_halt) begin
                     state_d  = HALT;
                     phase_d  = 3'b000;
                     beat_d   = 3'b000;
                     resume_d = step_halt ? BT_W1 : next_beat;
                  end else begin
                     phase_d = PH_T1;
                     beat_d  = next_beat;
                  end
               end
            endcase
         end
      endcase
   end

   assign t1        = phase_q[0];
   assign t2        = phase_q[1];
   assign t3        = phase_q[2];
   assign w1        = beat_q[0];
   assign w2        = beat_q[1];
   assign w3        = beat_q[2];
   assign running   = (state_q == RUN);
   assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// tb/tb_beat_sequencer.sv - directed scoreboard bench for beat_sequencer (CNT_W=4).
module tb_beat_sequencer;

   logic       clk;
   logic       clr;
   logic       qd;
   logic       short;
   logic       long;
   logic       stop;
`ifdef BEAT_SINGLE_STEP_EN
   logic       step_mode;
`endif
   logic       t1, t2, t3, w1, w2, w3, running;
   logic [3:0] instr_cnt;

   int          ncmp = 0;
   int          nfail = 0;
   int          c = 0;
   bit          qd_hold = 0;
   logic [10:0] sb[$];

   beat_sequencer #(.CNT_W(4)) dut (
      .clk(clk), .clr(clr), .qd(qd), .short(short), .long(long), .stop(stop),
`ifdef BEAT_SINGLE_STEP_EN
      .step_mode(step_mode),
`endif
      .t1(t1), .t2(t2), .t3(t3), .w1(w1), .w2(w2), .w3(w3),
      .running(running), .instr_cnt(instr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not reach summary");
      $fatal(1, "watchdog");
   end

   // {running, t1, t2, t3, w1, w2, w3, instr_cnt}
   function automatic logic [10:0] ex(input bit r, input int ph, input int w, input int cv);
      logic [3:0] cc;
      cc = cv[3:0];
      return {r, ph == 1, ph == 2, ph == 3, w == 1, w == 2, w == 3, cc};
   endfunction

   task automatic check(input string tag);
      logic [10:0] e, o;
      e = sb.pop_front();
      o = {running, t1, t2, t3, w1, w2, w3, instr_cnt};
      ncmp++;
      assert (o === e) else begin
         nfail++;
         $error("FAIL %s: observed=%b expected=%b", tag, o, e);
      end
   endtask

   task automatic step(input string tag, input logic [10:0] e);
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      check(tag);
   endtask

   task automatic noise();
      {short, long, stop} = 3'($urandom);
      if (!qd_hold) qd = 1'($urandom);
   endtask

   // One beat: T1, T2, T3 with junk on the ignored inputs, then the T3-sampled values.
   task automatic beat(input string tag, input bit go, input int w, input int cv,
                       input bit sh, input bit lg, input bit sp);
      if (go) qd = 1'b1;
      step(tag, ex(1, 1, w, cv));
      if (!qd_hold) qd = 1'b0;
      noise();
      step(tag, ex(1, 2, w, cv));
      noise();
      step(tag, ex(1, 3, w, cv));
      short = sh; long = lg; stop = sp;
      if (!qd_hold) qd = 1'b0;
   endtask

   initial begin
      clr = 1'b0; qd = 1'b0; short = 1'b0; long = 1'b0; stop = 1'b0;
`ifdef BEAT_SINGLE_STEP_EN
      step_mode = 1'b0;
`endif
      step("reset", ex(0, 0, 0, 0));
      clr = 1'b1;
      step("idle", ex(0, 0, 0, 0));

      // short held: W1 only, counter steps at each W1 T3
      short = 1'b1;
      beat("short0", 1, 1, 0, 1, 0, 0); c = 1;
      beat("short1", 0, 1, c, 1, 0, 0); c = 2;
      // long: W1 -> W2 -> W3 -> W1
      beat("long_w1", 0, 1, c, 0, 1, 0);
      beat("long_w2", 0, 2, c, 0, 1, 0);
      beat("long_w3", 0, 3, c, 0, 0, 0); c = 3;
      // stop in W1 without short: resume at W2
      beat("stop_w1", 0, 1, c, 0, 0, 1);
      step("halt_a", ex(0, 0, 0, c));
      step("halt_b", ex(0, 0, 0, c));
      beat("resume_w2", 1, 2, c, 0, 0, 0); c = 4;
      // short+long+stop in W1: cycle ends, halt, resume W1
      beat("sls_w1", 0, 1, c, 1, 1, 1); c = 5;
      step("halt_c", ex(0, 0, 0, c));
      // qd held high across a whole run and halt: single start only
      qd_hold = 1;
      beat("hold_w1", 1, 1, c, 0, 0, 0);
      beat("hold_w2", 0, 2, c, 0, 0, 1); c = 6;
      for (int i = 0; i < 4; i++) step("hold_halt", ex(0, 0, 0, c));
      qd_hold = 0; qd = 1'b0;
      step("hold_rel", ex(0, 0, 0, c));

      // asynchronous clear during W2 T2
      beat("pre_clr", 1, 1, c, 0, 0, 0);
      step("clr_t1", ex(1, 1, 2, c));
      step("clr_t2", ex(1, 2, 2, c));
      #2 clr = 1'b0;
      #1 sb.push_back(ex(0, 0, 0, 0));
      check("clr_async");
      step("clr_held", ex(0, 0, 0, 0));
      clr = 1'b1; c = 0;
      beat("post_clr", 1, 1, c, 1, 0, 0); c = 1;

      // counter wrap 15 -> 0
      for (int i = 0; i < 16; i++) begin
         beat("wrap", 0, 1, c, 1, 0, 0);
         c = (c + 1) % 16;
      end
      beat("wrap_stop", 0, 1, c, 1, 0, 1); c = (c + 1) % 16;
      step("wrap_halt", ex(0, 0, 0, c));

`ifdef BEAT_SINGLE_STEP_EN
      step_mode = 1'b1;
      for (int r = 0; r < 2; r++) begin
         beat("step_w1", 1, 1, c, 0, 1, 0);
         beat("step_w2", 0, 2, c, 0, 1, 0);
         beat("step_w3", 0, 3, c, 0, 1, 0); c = (c + 1) % 16;
         step("step_halt", ex(0, 0, 0, c));
         step("step_halt2", ex(0, 0, 0, c));
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
